phase_pd_vote_filter: RTL and testbench

//  Upstream stage of the coarse phase-compensation controller. Accumulates raw
//  per-lane early/late phase-detector samples over a fixed window and issues one

---
 rtl/phase_pd_vote_filter.sv | 156 +++++++++++++++
 tb/tb_phase_pd_vote_filter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_pd_vote_filter.sv
// Per-lane early/late vote filter ahead of the coarse phase-compensation controller.
// One registered direction/dead-band decision per window of WIN accepted PD samples.
module phase_pd_vote_filter #(
    parameter int NLANE    = 16,
    parameter int WIN      = 16,
    parameter int THRESH   = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             enable,
    input  logic             pd_valid,
    input  logic [NLANE-1:0] pd_raw,
    output logic [NLANE-1:0] pd_out,
    output logic [NLANE-1:0] freeze,
    output logic             dec_strobe,
    output logic [NLANE-1:0] locked
);

    localparam int AW = $clog2(WIN) + 2;
    localparam int CW = $clog2(WIN);
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic signed [AW-1:0] ACC_ONE   = AW'(1);
    localparam logic signed [AW-1:0] ACC_THR_P = AW'(THRESH);
    localparam logic signed [AW-1:0] ACC_THR_N = -ACC_THR_P;
    localparam logic [CW-1:0]        CNT_LAST  = CW'(WIN - 1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [LW-1:0]        LOCK_MAX  = LW'(LOCK_CNT);
    localparam logic [LW-1:0]        LOCK_ONE  = LW'(1);

    // Dead-band windows bump the lock count (saturating); any direction restarts it.
    function automatic logic [LW-1:0] lock_step(input logic [LW-1:0] cnt, input logic hold);
        logic [LW-1:0] res;
        if (!hold) begin
            res = '0;
        end else if (cnt == LOCK_MAX) begin
            res = LOCK_MAX;
        end else begin
            res = cnt + LOCK_ONE;
        end
        return res;
    endfunction

    logic signed [AW-1:0] r_acc      [NLANE];
    logic signed [AW-1:0] w_acc_nxt  [NLANE];
    logic [LW-1:0]        r_lock_cnt [NLANE];
    logic [LW-1:0]        w_lock_nxt [NLANE];
    logic [CW-1:0]        r_win_cnt;
    logic [NLANE-1:0]     w_pd_nxt;
    logic [NLANE-1:0]     w_frz_nxt;
    logic [NLANE-1:0]     w_locked_nxt;
    logic                 w_accept;
    logic                 w_close;

    // Sample acceptance and window-close detection.
    always_comb begin
        w_accept = enable & pd_valid;
        w_close  = w_accept & (r_win_cnt == CNT_LAST);
    end

    // Per-lane vote update and the decision that would be issued if this sample closes the window.
    always_comb begin
        w_pd_nxt     = '0;
        w_frz_nxt    = '0;
        w_locked_nxt = '0;
        for (int i = 0; i < NLANE; i++) begin
            w_acc_nxt[i]  = '0;
            w_lock_nxt[i] = '0;
        end
        for (int i = 0; i < NLANE; i++) begin
            if (pd_raw[i]) begin
                w_acc_nxt[i] = r_acc[i] + ACC_ONE;
            end else begin
                w_acc_nxt[i] = r_acc[i] - ACC_ONE;
            end
            if (w_acc_nxt[i] >= ACC_THR_P) begin
                w_pd_nxt[i]  = 1'b1;
                w_frz_nxt[i] = 1'b0;
            end else if (w_acc_nxt[i] <= ACC_THR_N) begin
                w_pd_nxt[i]  = 1'b0;
                w_frz_nxt[i] = 1'b0;
            end else begin
                // Inside the dead band the controller keeps its last direction.
                w_pd_nxt[i]  = pd_out[i];
                w_frz_nxt[i] = 1'b1;
            end
            w_lock_nxt[i]   = lock_step(r_lock_cnt[i], w_frz_nxt[i]);
            w_locked_nxt[i] = (w_lock_nxt[i] == LOCK_MAX);
        end
    end

    // Window counter and vote accumulators.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_win_cnt <= '0;
            for (int i = 0; i < NLANE; i++) begin
                r_acc[i] <= '0;
            end
        end else if (!enable || w_close) begin
            r_win_cnt <= '0;
            for (int i = 0; i < NLANE; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            r_win_cnt <= r_win_cnt + CNT_ONE;
            for (int i = 0; i < NLANE; i++) begin
                r_acc[i] <= w_acc_nxt[i];
            end
        end else begin
            r_win_cnt <= r_win_cnt;
        end
    end

    // Lock counters advance only on a real window close.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NLANE; i++) begin
                r_lock_cnt[i] <= '0;
            end
        end else if (!enable) begin
            for (int i = 0; i < NLANE; i++) begin
                r_lock_cnt[i] <= '0;
            end
        end else if (w_close) begin
            for (int i = 0; i < NLANE; i++) begin
                r_lock_cnt[i] <= w_lock_nxt[i];
            end
        end else begin
            for (int i = 0; i < NLANE; i++) begin
                r_lock_cnt[i] <= r_lock_cnt[i];
            end
        end
    end

    // Registered decision outputs; freeze comes out of reset asserted so the controller holds.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pd_out     <= '0;
            freeze     <= '1;
            dec_strobe <= 1'b0;
            locked     <= '0;
        end else if (!enable) begin
            dec_strobe <= 1'b0;
            locked     <= '0;
        end else if (w_close) begin
            pd_out     <= w_pd_nxt;
            freeze     <= w_frz_nxt;
            dec_strobe <= 1'b1;
            locked     <= w_locked_nxt;
        end else begin
            dec_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_phase_pd_vote_filter.sv
// Scoreboard bench for phase_pd_vote_filter: directed windows push expected decisions,
// a negedge monitor pops them on every dec_strobe.
module tb_phase_pd_vote_filter;
    localparam int NL = 16;

    logic          clk = 1'b0;
    logic          resetb;
    logic          enable;
    logic          pd_valid;
    logic [NL-1:0] pd_raw;
    logic [NL-1:0] pd_out;
    logic [NL-1:0] freeze;
    logic          dec_strobe;
    logic [NL-1:0] locked;

    phase_pd_vote_filter dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (enable),
        .pd_valid   (pd_valid),
        .pd_raw     (pd_raw),
        .pd_out     (pd_out),
        .freeze     (freeze),
        .dec_strobe (dec_strobe),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int n_strobe    = 0;
    int exp_strobes = 0;

    logic [3*NL-1:0] exp_q [$];
    logic [NL-1:0]   m_pd;
    logic [NL-1:0]   m_frz;
    int              m_lk   [NL];
    int              late_n [NL];

    task automatic check(input string name, input logic [3*NL-1:0] act, input logic [3*NL-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [NL-1:0] m_locked();
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = (m_lk[i] == 8);
        return r;
    endfunction

    // Reference decision: v = late - early = 2*late - 16, threshold 4, lock after 8.
    task automatic model_close();
        for (int i = 0; i < NL; i++) begin
            int v;
            v = 2 * late_n[i] - 16;
            if (v >= 4) begin
                m_pd[i] = 1'b1; m_frz[i] = 1'b0; m_lk[i] = 0;
            end else if (v <= -4) begin
                m_pd[i] = 1'b0; m_frz[i] = 1'b0; m_lk[i] = 0;
            end else begin
                m_frz[i] = 1'b1;
                if (m_lk[i] < 8) m_lk[i] = m_lk[i] + 1;
            end
        end
        exp_q.push_back({m_pd, m_frz, m_locked()});
        exp_strobes++;
    endtask

    task automatic model_reset();
        m_pd  = '0;
        m_frz = '1;
        for (int i = 0; i < NL; i++) m_lk[i] = 0;
    endtask

    task automatic set_all(input int n);
        for (int i = 0; i < NL; i++) late_n[i] = n;
    endtask

    task automatic drive(input logic [NL-1:0] raw, input logic v);
        pd_raw   = raw;
        pd_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NL-1:0] sample_bits(input int s);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = (s < late_n[i]);
        return r;
    endfunction

    task automatic run_window(input bit gaps);
        for (int s = 0; s < 16; s++) begin
            if (s == 15) model_close();
            drive(sample_bits(s), 1'b1);
            if (gaps) drive(~sample_bits(s), 1'b0);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (resetb === 1'b1 && dec_strobe === 1'b1) begin
                n_strobe++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=%h required=none", {pd_out, freeze, locked});
                end else begin
                    check("strobe_outputs", {pd_out, freeze, locked}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int guard;
        resetb   = 1'b0;
        enable   = 1'b0;
        pd_valid = 1'b0;
        pd_raw   = '0;
        model_reset();
        #12;
        check("reset_outputs", {pd_out, freeze, locked}, {16'h0000, 16'hFFFF, 16'h0000});
        check("reset_strobe", {47'd0, dec_strobe}, 48'd0);
        @(posedge clk);
        #1;
        resetb = 1'b1;
        enable = 1'b1;

        // All lanes late for a full window.
        set_all(16);
        run_window(1'b0);
        check("all_late", {pd_out, freeze, 16'h0000}, {16'hFFFF, 16'h0000, 16'h0000});

        // Lane0 v=+4 issues a direction, lane1 v=+2 freezes and keeps pd_out=1.
        set_all(8);
        late_n[0] = 10;
        late_n[1] = 9;
        run_window(1'b0);
        check("dead_band_lanes01", {46'd0, pd_out[1:0]}, {46'd0, 2'b11});
        check("dead_band_frz01", {46'd0, freeze[1:0]}, {46'd0, 2'b10});

        // Asynchronous reset mid-window.
        set_all(16);
        for (int s = 0; s < 5; s++) drive(sample_bits(s), 1'b1);
        #3;
        resetb = 1'b0;
        #1;
        check("midrun_reset_outputs", {pd_out, freeze, locked}, {16'h0000, 16'hFFFF, 16'h0000});
        check("midrun_reset_strobe", {47'd0, dec_strobe}, 48'd0);
        model_reset();
        @(posedge clk);
        #1;
        resetb = 1'b1;

        // Lock: eight dead-band windows, then a strong window, then restart.
        set_all(8);
        for (int w = 0; w < 8; w++) begin
            run_window(1'b0);
            if (w == 6) check("lock_not_yet", {47'd0, locked[3]}, 48'd0);
        end
        check("lock_rise", {47'd0, locked[3]}, 48'd1);
        late_n[3] = 16;
        run_window(1'b0);
        check("lock_drop", {46'd0, locked[3], pd_out[3]}, {46'd0, 2'b01});
        late_n[3] = 8;
        run_window(1'b0);
        check("lock_restart", {47'd0, locked[3]}, 48'd0);

        // Gapped sampling, then enable dropped on the closing sample.
        set_all(2);
        run_window(1'b1);
        set_all(16);
        for (int s = 0; s < 15; s++) drive(sample_bits(s), 1'b1);
        enable = 1'b0;
        drive(sample_bits(15), 1'b1);
        for (int k = 0; k < 3; k++) drive('0, 1'b0);
        for (int i = 0; i < NL; i++) m_lk[i] = 0;
        check("enable_drop_hold", {pd_out, freeze, locked}, {m_pd, m_frz, 16'h0000});
        enable = 1'b1;
        run_window(1'b0);
        check("after_enable_window", {pd_out, freeze, 16'h0000}, {16'hFFFF, 16'h0000, 16'h0000});

        // Long dead-band run: lock counter must saturate, not wrap.
        set_all(8);
        for (int w = 0; w < 300; w++) run_window(1'b0);
        check("lock_saturated", {32'd0, locked}, {32'd0, 16'hFFFF});

        guard = 0;
        drive('0, 1'b0);
        while (exp_q.size() != 0 && guard < 10) begin
            drive('0, 1'b0);
            guard++;
        end
        drive('0, 1'b0);
        check("pending_expectations", 48'(exp_q.size()), 48'd0);
        check("strobe_count", 48'(n_strobe), 48'(exp_strobes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
